// File: rtl/button_debouncer.sv
// button_debouncer
// Push-button front end. Each raw pad input passes through a 2-flop
// synchroniser into a two-state FSM with a stability counter. A new level
// is accepted only after it has been seen on the synchronised input for
// DEBOUNCE_CYCLES+1 consecutive clocks. Raw-to-output latency is
// DEBOUNCE_CYCLES+2 clocks.
//
// Optional feature macro: BUTTON_EVENTS_EN
//   defined   -> press_pulse / release_pulse carry registered 1-cycle strobes
//                that coincide with the cycle buttons[i] first shows a new level
//   undefined -> both pulse buses are tied to 0 and no pulse flops exist
//
// state    | meaning
// ---------+-------------------------------------------------------------
// STABLE   | synchronised input matches buttons[i]; counter idle
// SETTLING | input differs from buttons[i]; counting consecutive mismatches
module button_debouncer #(
   parameter int NUM_BUTTONS     = 3,
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = 16
) (
   input  logic                   wb_clk_i,
   input  logic                   wb_rst_i,
   input  logic [NUM_BUTTONS-1:0] buttons_raw,
   output logic [NUM_BUTTONS-1:0] buttons,
   output logic [NUM_BUTTONS-1:0] press_pulse,
   output logic [NUM_BUTTONS-1:0] release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE   = 1'b0,
      ST_SETTLING = 1'b1
   } state_t;

   logic [NUM_BUTTONS-1:0] sync1;
   logic [NUM_BUTTONS-1:0] sync2;

   // Two-flop synchroniser for every pad input
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= buttons_raw;
         sync2 <= sync1;
      end
   end

   for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
      state_t           state;
      state_t           state_nxt;
      logic [CNT_W-1:0] cnt;
      logic [CNT_W-1:0] cnt_nxt;
      logic             btn_q;
      logic             differ;
      logic             commit;

      assign differ     = sync2[i] ^ btn_q;
      assign buttons[i] = btn_q;

      // State register, stability counter and accepted level
      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) begin
            state <= ST_STABLE;
            cnt   <= '0;
            btn_q <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (commit) begin
               btn_q <= sync2[i];
            end
         end
      end

      // Next-state decode
      always_comb begin
         state_nxt = state;
         case (state)
            ST_STABLE: begin
               if (differ) begin
                  state_nxt = ST_SETTLING;
               end
            end
            ST_SETTLING: begin
               if (!differ || (cnt == CNT_LAST)) begin
                  state_nxt = ST_STABLE;
               end
            end
            default: state_nxt = ST_STABLE;
         endcase
      end

      // Counter update and commit strobe; the counter stops at CNT_LAST
      always_comb begin
         cnt_nxt = cnt;
         commit  = 1'b0;
         case (state)
            ST_STABLE: begin
               if (differ) begin
                  cnt_nxt = '0;
               end
            end
            ST_SETTLING: begin
               if (differ) begin
                  if (cnt == CNT_LAST) begin
                     commit  = 1'b1;
                     cnt_nxt = '0;
                  end else begin
                     cnt_nxt = cnt + 1'b1;
                  end
               end
            end
            default: begin
               cnt_nxt = '0;
            end
         endcase
      end

`ifdef BUTTON_EVENTS_EN
      logic press_q;
      logic release_q;

      // Edge strobes registered alongside the committed level
      always_ff @(posedge wb_clk_i) begin
         if (wb_rst_i) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
         end else begin
            press_q   <= commit &  sync2[i];
            release_q <= commit & ~sync2[i];
         end
      end

      assign press_pulse[i]   = press_q;
      assign release_pulse[i] = release_q;
`else
      assign press_pulse[i]   = 1'b0;
      assign release_pulse[i] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4 (latency 6 edges).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_button_debouncer;

   logic       wb_clk_i = 1'b0;
   logic       wb_rst_i;
   logic [2:0] buttons_raw;
   logic [2:0] buttons;
   logic [2:0] press_pulse;
   logic [2:0] release_pulse;

   int errors = 0;
   int checks = 0;

`ifdef BUTTON_EVENTS_EN
   localparam bit EV = 1'b1;
`else
   localparam bit EV = 1'b0;
`endif

   always #5 wb_clk_i = ~wb_clk_i;

   button_debouncer #(
      .NUM_BUTTONS    (3),
      .DEBOUNCE_CYCLES(4),
      .CNT_W          (16)
   ) dut (
      .wb_clk_i     (wb_clk_i),
      .wb_rst_i     (wb_rst_i),
      .buttons_raw  (buttons_raw),
      .buttons      (buttons),
      .press_pulse  (press_pulse),
      .release_pulse(release_pulse)
   );

   function automatic logic [2:0] ev(input logic [2:0] m);
      return EV ? m : 3'b000;
   endfunction

   task automatic tick();
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
   endtask

   task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [2:0] b,
                          input logic [2:0] p, input logic [2:0] r);
      chk({tag, "/buttons"}, buttons, b);
      chk({tag, "/press"}, press_pulse, p);
      chk({tag, "/release"}, release_pulse, r);
   endtask

   // Raw level already set; first tick is the capture edge E, commit at E+6.
   task automatic wait_commit(input string tag, input logic [2:0] pre,
                              input logic [2:0] post, input logic [2:0] pe,
                              input logic [2:0] re);
      for (int k = 1; k < 7; k++) begin
         tick();
         chk_all({tag, " settle"}, pre, 3'b000, 3'b000);
      end
      tick();
      chk_all({tag, " commit"}, post, ev(pe), ev(re));
      tick();
      chk_all({tag, " after"}, post, 3'b000, 3'b000);
   endtask

   initial begin
      // 1. Reset with all buttons held
      wb_rst_i    = 1'b1;
      buttons_raw = 3'b111;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all("reset", 3'b000, 3'b000, 3'b000);
      end
      wb_rst_i = 1'b0;
      wait_commit("reset_release", 3'b000, 3'b111, 3'b111, 3'b000);

      // Return to idle, all released together
      buttons_raw = 3'b000;
      wait_commit("release_all", 3'b111, 3'b000, 3'b000, 3'b111);

      // 2. Clean press on channel 0
      buttons_raw = 3'b001;
      wait_commit("press0", 3'b000, 3'b001, 3'b001, 3'b000);

      // 3a. 3-cycle glitch on channel 1 is rejected
      buttons_raw = 3'b011;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_all("glitch3 high", 3'b001, 3'b000, 3'b000);
      end
      buttons_raw = 3'b001;
      for (int k = 0; k < 10; k++) begin
         tick();
         chk_all("glitch3 low", 3'b001, 3'b000, 3'b000);
      end

      // 3b. 5-cycle high is accepted, then its fall is accepted too
      buttons_raw = 3'b011;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_all("pulse5 high", 3'b001, 3'b000, 3'b000);
      end
      buttons_raw = 3'b001;
      tick();
      chk_all("pulse5 pre", 3'b001, 3'b000, 3'b000);
      tick();
      chk_all("pulse5 commit", 3'b011, ev(3'b010), 3'b000);
      for (int k = 8; k <= 11; k++) begin
         tick();
         chk_all("pulse5 hold", 3'b011, 3'b000, 3'b000);
      end
      tick();
      chk_all("pulse5 fall", 3'b001, 3'b000, ev(3'b010));
      tick();
      chk_all("pulse5 after", 3'b001, 3'b000, 3'b000);

      // 4. Bounce on channel 2: 2-cycle toggles, then hold high
      for (int t = 0; t < 20; t++) begin
         buttons_raw[2] = ((t / 2) % 2) == 0;
         tick();
         chk_all("bounce", 3'b001, 3'b000, 3'b000);
      end
      buttons_raw[2] = 1'b1;
      wait_commit("bounce_settle", 3'b001, 3'b101, 3'b100, 3'b000);

      // 5. Reset in the middle of a channel 0 press (cnt==2)
      buttons_raw = 3'b100;
      wait_commit("release0", 3'b101, 3'b100, 3'b000, 3'b001);
      buttons_raw = 3'b101;
      for (int k = 1; k <= 5; k++) begin
         tick();
         chk_all("midsettle", 3'b100, 3'b000, 3'b000);
      end
      wb_rst_i = 1'b1;
      for (int k = 0; k < 2; k++) begin
         tick();
         chk_all("midsettle reset", 3'b000, 3'b000, 3'b000);
      end
      wb_rst_i = 1'b0;
      wait_commit("post_reset", 3'b000, 3'b101, 3'b101, 3'b000);

      // 6. Press then release channel 1
      buttons_raw = 3'b111;
      wait_commit("press1", 3'b101, 3'b111, 3'b010, 3'b000);
      buttons_raw = 3'b101;
      wait_commit("release1", 3'b111, 3'b101, 3'b000, 3'b010);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
